shadow_stack_monitor: RTL
=========================

// Module: shadow_stack_monitor
// PURPOSE
//  Receiving end of the observer event link. Consumes single-cycle call (jal) and return (jr)
//  pulses with their address, keeps a hardware shadow stack of return addresses, and compares
//  each return target against the top entry. Raises a sticky alarm with a cause code on
//  mismatch, underflow, overflow or overrun. Sits between the observer and the SoC alarm/IRQ logic.
// PARAMETERS
//  DEPTH  64  shadow stack entries; power of two.
//  AW     6   log2(DEPTH); pointer width. mon_depth_o is AW+1 bits wide.
//  DW     32  address/data width.
// PORTS
//  clk            in   1     single clock; all logic on its rising edge.
//  reset          in   1     asynchronous, active-low reset.
//  mon_jal_i      in   1     call event pulse; push mon_address_i.
//  mon_jr_i       in   1     return event pulse; pop and compare with mon_address_i.
//  mon_address_i  in   DW    return address (on jal) / actual return target (on jr).
//  mon_clear_i    in   1     synchronous clear of alarm and cause; stack contents untouched.
//  mon_busy_o     out  1     high while a pop/compare is in flight.
//  mon_alarm_o    out  1     sticky violation flag.
//  mon_cause_o    out  3     0 none, 1 mismatch, 2 underflow, 3 overflow, 4 overrun, 5 collision.
//  mon_depth_o    out  AW+1  current number of valid entries, 0..DEPTH.
// BEHAVIOUR
//  Reset (reset==0, async): sp=0, state=IDLE, mon_busy_o=0, mon_alarm_o=0, mon_cause_o=0,
//   mon_depth_o=0. Memory contents undefined and never read before written.
//  FSM states IDLE, RD, CMP.
//  IDLE, mon_jal_i=1, mon_jr_i=0: if sp<DEPTH, write mem[sp]=mon_address_i, sp<=sp+1
//   (depth visible next cycle); else no write, sp unchanged, raise overflow(3).
//  IDLE, mon_jr_i=1, mon_jal_i=0: if sp==0, raise underflow(2) next edge, stay IDLE;
//   else sp<=sp-1, read address sp-1 issued, latch mon_address_i into cmp_addr, go RD.
//  RD: sync memory read completes; go CMP. busy=1.
//  CMP: if mem data != cmp_addr raise mismatch(1); go IDLE. busy=1.
//   mon_busy_o = (state!=IDLE); alarm for a jr appears 2 cycles after the pulse is sampled.
//  Both mon_jal_i and mon_jr_i high in IDLE: no stack change, raise collision(5).
//  Any mon_jal_i/mon_jr_i sampled in RD or CMP: event dropped, raise overrun(4);
//   the in-flight compare still completes normally.
//  Alarm latching: first fault sets mon_alarm_o=1 and mon_cause_o; later faults do not
//   overwrite cause until cleared. Stack keeps operating while alarm is set.
//  mon_clear_i: clears alarm/cause next edge; a fault raised in the same cycle wins
//   (alarm remains set with the new cause).
//  Pointer arithmetic is AW+1 bits; sp never wraps (saturates at 0 and DEPTH).
//  Async reset mid-compare aborts it; no alarm generated.
// STRUCTURE
//  Shared package/include: cause codes (CAUSE_NONE..CAUSE_COLLISION), FSM state encodings,
//   default DEPTH/AW, so software-visible registers and the observer agree on values.
//  One sub-module: shadow_stack_ram (DEPTH x DW, 1 write port, 1 registered read port,
//   no reset) so it infers block RAM on the De0_nano target.
//  Top holds FSM, sp, cmp_addr, alarm/cause registers.
// TESTING
//  1. jal 0x100, jal 0x200, jr 0x200, jr 0x100 -> depth 1,2,1,0; alarm stays 0; busy 2 cycles per jr.
//  2. jal 0x100, jr 0x104 -> 2 cycles after jr: alarm=1, cause=1, depth=0.
//  3. After reset, jr 0x40 -> alarm=1, cause=2 next cycle, busy never asserts, depth=0.
//  4. 64 jal pushes then a 65th -> depth=64, alarm=1, cause=3; next jr pops entry 63 cleanly.
//  5. jr then jal one cycle later (during RD) -> cause=4, depth unchanged by jal; compare
//     result unaffected; then clear pulse -> alarm=0, cause=0.
//  6. jal+jr same cycle -> cause=5, depth unchanged; reset asserted during CMP -> all outputs 0
//     immediately, no alarm after release.

Source files
------------

// File: rtl/shadow_stack_monitor_pkg.sv
// Shared definitions for the shadow stack monitor.
// Cause codes and FSM encodings seen by software and the observer.
package shadow_stack_monitor_pkg;

  localparam int DEPTH_DEF = 64;
  localparam int AW_DEF    = 6;
  localparam int DW_DEF    = 32;

  typedef enum logic [2:0] {
    CAUSE_NONE      = 3'd0,
    CAUSE_MISMATCH  = 3'd1,
    CAUSE_UNDERFLOW = 3'd2,
    CAUSE_OVERFLOW  = 3'd3,
    CAUSE_OVERRUN   = 3'd4,
    CAUSE_COLLISION = 3'd5
  } cause_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CMP  = 2'd2
  } state_t;

endpackage

// File: rtl/shadow_stack_ram.sv
// Shadow stack storage: one write port, one registered read port.
// No reset so it maps onto block RAM.
module shadow_stack_ram
  import shadow_stack_monitor_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // write on push, registered read on pop
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/shadow_stack_monitor.sv
// Shadow stack monitor: tracks call/return pairs and
// raises a sticky alarm with a cause code on a violation.
module shadow_stack_monitor
  import shadow_stack_monitor_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mon_jal_i,
  input  logic          mon_jr_i,
  input  logic [DW-1:0] mon_address_i,
  input  logic          mon_clear_i,
  output logic          mon_busy_o,
  output logic          mon_alarm_o,
  output logic [2:0]    mon_cause_o,
  output logic [AW:0]   mon_depth_o
);

  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

  state_t        state, state_nx;
  logic [AW:0]   sp, sp_m1;
  logic [DW-1:0] cmp_addr, rd_data;
  logic          idle, full, empty;
  logic          push, pop, fault;
  cause_t        fault_cause, cause_q;
  logic          alarm_q;

  assign idle  = (state == ST_IDLE);
  assign full  = (sp == SP_FULL);
  assign empty = (sp == '0);
  assign sp_m1 = sp - SP_ONE;
  assign push  = idle & mon_jal_i & ~mon_jr_i & ~full;
  assign pop   = idle & mon_jr_i & ~mon_jal_i & ~empty;

  shadow_stack_ram #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(sp[AW-1:0]),
    .wdata(mon_address_i),
    .re   (pop),
    .raddr(sp_m1[AW-1:0]),
    .rdata(rd_data)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (pop) state_nx = ST_RD;
      ST_RD:   state_nx = ST_CMP;
      ST_CMP:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // outputs derived from state
  always_comb begin
    mon_busy_o = (state != ST_IDLE);
  end

  // stack pointer and latched return target
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp       <= '0;
      cmp_addr <= '0;
    end else begin
      if (push)     sp <= sp + SP_ONE;
      else if (pop) sp <= sp_m1;
      if (pop) cmp_addr <= mon_address_i;
    end
  end

  // fault detection; mismatch outranks a coincident overrun
  always_comb begin
    fault_cause = CAUSE_NONE;
    if (idle) begin
      if (mon_jal_i & mon_jr_i)   fault_cause = CAUSE_COLLISION;
      else if (mon_jal_i & full)  fault_cause = CAUSE_OVERFLOW;
      else if (mon_jr_i & empty)  fault_cause = CAUSE_UNDERFLOW;
    end else begin
      if (state == ST_CMP && rd_data != cmp_addr)
        fault_cause = CAUSE_MISMATCH;
      else if (mon_jal_i | mon_jr_i)
        fault_cause = CAUSE_OVERRUN;
    end
  end

  assign fault = (fault_cause != CAUSE_NONE);

  // sticky alarm; a new fault beats a clear in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else if (fault && (!alarm_q || mon_clear_i)) begin
      alarm_q <= 1'b1;
      cause_q <= fault_cause;
    end else if (mon_clear_i) begin
      alarm_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end
  end

  assign mon_alarm_o = alarm_q;
  assign mon_cause_o = cause_q;
  assign mon_depth_o = sp;

endmodule
